trn_mwr_tx: RTL and testbench
=============================

TRN_MWR_TX -- requirements
Module: trn_mwr_tx

Interface
REQ-001 SHALL have the parameter: REQ_ID_FROM_CFG, default 1; 1 means the requester ID is taken from cfg_bus/device/function_number, 0 means the requester ID is 16'h0000.
REQ-002 SHALL have the port: sys_clk  in  1  the single clock, also used as trn_clk.
REQ-003 SHALL have the port: sys_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have the port: req_valid  in  1  request strobe.
REQ-005 SHALL have the port: req_ready  out  1  request acceptable this cycle.
REQ-006 SHALL have the ports: req_addr in 30 (DW address [31:2]); req_data in 32; req_be in 4 (first DW byte enables).
REQ-007 SHALL have the ports: cfg_bus_number in 8; cfg_device_number in 5; cfg_function_number in 3 (requester ID source).
REQ-008 SHALL have the ports: trn_lnk_up_n in 1; trn_tdst_rdy_n in 1; trn_tbuf_av in 6; trn_tcfg_req_n in 1; trn_terr_drop_n in 1.
REQ-009 SHALL have the ports: trn_td out 64; trn_trem_n out 1; trn_tsof_n out 1; trn_teof_n out 1; trn_tsrc_rdy_n out 1.
REQ-010 SHALL have the ports: trn_tsrc_dsc_n out 1; trn_terrfwd_n out 1; trn_tstr_n out 1; trn_tcfg_gnt_n out 1.
REQ-011 SHALL have the ports: tx_count out 16 and drop_count out 16 (statistics).

Function
REQ-012 SHALL implement the states IDLE, HDR and DAT.
REQ-013 SHALL drive req_ready=1 only when all of the following hold: state IDLE, trn_lnk_up_n=0, trn_tbuf_av[1]=1, trn_tcfg_req_n=1.
REQ-014 SHALL register the request on acceptance (req_valid & req_ready) and move IDLE->HDR; the first beat SHALL be presented in the cycle after acceptance.
REQ-015 SHALL present, in HDR: trn_td={32'h4000_0001, req_id, tag, 4'h0, be}, trn_tsof_n=0, trn_teof_n=1, trn_trem_n=0, trn_tsrc_rdy_n=0.
REQ-016 SHALL present, in DAT: trn_td={addr,2'b00, data}, trn_tsof_n=1, trn_teof_n=0, trn_trem_n=0, trn_tsrc_rdy_n=0.
REQ-017 SHALL transfer a beat only in a cycle with trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0; on transfer HDR->DAT and DAT->IDLE.
REQ-018 SHALL hold trn_td and all framing signals stable while trn_tdst_rdy_n=1.
REQ-019 SHALL drive trn_tsrc_rdy_n=1, trn_tsof_n=1 and trn_teof_n=1 in IDLE; trn_td SHALL be 0 in IDLE.
REQ-020 SHALL keep an 8-bit tag counter that increments once on each DAT transfer and wraps from 255 to 0.
REQ-021 SHALL drive trn_tcfg_gnt_n=0 whenever in IDLE with trn_tcfg_req_n=0, and SHALL never grant mid-TLP.
REQ-022 SHALL, if trn_lnk_up_n=1 in HDR or DAT, abandon the TLP, return to IDLE next cycle with trn_tsrc_rdy_n=1, and leave the tag unchanged.
REQ-023 SHALL tie off trn_tsrc_dsc_n, trn_terrfwd_n and trn_tstr_n to 1.
REQ-024 SHALL, when both trn_tdst_rdy_n=0 and trn_lnk_up_n=1 occur in DAT, treat the link drop as taking precedence: no count, no tag increment.

Reset
REQ-025 SHALL, on sys_rst=1 at a clock edge, go to IDLE with tag=0, req_ready=0, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_trem_n=0, trn_tcfg_gnt_n=1, trn_td=0, tx_count=0, drop_count=0.
REQ-026 SHALL, on reset asserted mid-TLP, abandon the TLP in the same edge with no counter update.

Configuration
REQ-027 SHALL, with TRN_MWR_TX_STATS_EN defined, increment tx_count on each DAT transfer and increment drop_count on each cycle with trn_terr_drop_n=0; both counters SHALL saturate at 16'hFFFF.
REQ-028 SHALL, without TRN_MWR_TX_STATS_EN, drive tx_count=0 and drop_count=0 constantly and include no counter logic.

Verification
REQ-029 SHALL be verified by a bench covering: addr=30'h0400_0000, data=32'hDEADBEEF, be=4'hF, bus/dev/fn=1/0/0, tdst_rdy_n=0 -> beat1 td=64'h4000_0001_0100_000F with tsof_n=0, beat2 td=64'h1000_0000_DEAD_BEEF with teof_n=0, tag then 1.
REQ-030 SHALL be verified by a bench covering: trn_tdst_rdy_n=1 for 5 cycles during HDR -> td/tsof_n held unchanged, DAT entered only after ready; tx_count=1 at the end.
REQ-031 SHALL be verified by a bench covering: 256 back-to-back requests -> the 257th header carries tag 8'h00; req_ready=0 while in HDR/DAT.
REQ-032 SHALL be verified by a bench covering: trn_tcfg_req_n=0 in IDLE with req_valid=1 -> tcfg_gnt_n=0, req_ready=0; trn_tcfg_req_n=0 during HDR -> tcfg_gnt_n=1 until return to IDLE.
REQ-033 SHALL be verified by a bench covering: trn_lnk_up_n=1 in DAT -> IDLE next cycle, tsrc_rdy_n=1, tag and tx_count unchanged; trn_tbuf_av[1]=0 -> req_ready=0.
REQ-034 SHALL be verified by a bench covering: trn_terr_drop_n=0 for 3 cycles with the stats macro defined -> drop_count=3; the same stimulus without the macro -> drop_count=0.

Source files
------------

// File: rtl/trn_mwr_tx.sv
// trn_mwr_tx: emits one single-DW posted memory write TLP (3DW header plus
// data, packed into two 64-bit beats) on a TRN transmit interface for each
// accepted request. The sequence is IDLE -> HDR -> DAT -> IDLE. A link-down
// during a TLP abandons it without touching the tag.
// Optional feature: define TRN_MWR_TX_STATS_EN to build the saturating
// tx_count/drop_count statistics counters. When it is undefined, both outputs
// are tied to zero.
module trn_mwr_tx #(
    parameter int REQ_ID_FROM_CFG = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [29:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_be,
    input  logic [7:0]  cfg_bus_number,
    input  logic [4:0]  cfg_device_number,
    input  logic [2:0]  cfg_function_number,
    input  logic        trn_lnk_up_n,
    input  logic        trn_tdst_rdy_n,
    input  logic [5:0]  trn_tbuf_av,
    input  logic        trn_tcfg_req_n,
    input  logic        trn_terr_drop_n,
    output logic [63:0] trn_td,
    output logic        trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    output logic        trn_tsrc_dsc_n,
    output logic        trn_terrfwd_n,
    output logic        trn_tstr_n,
    output logic        trn_tcfg_gnt_n,
    output logic [15:0] tx_count,
    output logic [15:0] drop_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DAT  = 2'd2;

    logic [1:0]  state;
    logic [29:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic [15:0] req_id_q;
    logic [7:0]  tag;

    logic        in_idle;
    logic        accept;
    logic        beat_xfer;
    logic        dat_done;
    logic [15:0] req_id;

    // Only the buffer-available bit for posted TLPs is relevant here.
    logic        unused_inputs;

    assign in_idle   = (state == IDLE);
    assign accept    = req_valid & req_ready;
    // Outside IDLE the source is always ready. A link drop overrides any transfer.
    assign beat_xfer = ~in_idle & ~trn_tdst_rdy_n & ~trn_lnk_up_n;
    assign dat_done  = (state == DAT) & beat_xfer;
    assign req_id    = (REQ_ID_FROM_CFG != 0)
                     ? {cfg_bus_number, cfg_device_number, cfg_function_number}
                     : 16'h0000;

    assign req_ready      = ~sys_rst & in_idle & ~trn_lnk_up_n
                          & trn_tbuf_av[1] & trn_tcfg_req_n;
    assign trn_tcfg_gnt_n = ~(~sys_rst & in_idle & ~trn_tcfg_req_n);

    assign trn_tsrc_dsc_n = 1'b1;
    assign trn_terrfwd_n  = 1'b1;
    assign trn_tstr_n     = 1'b1;

    // Sequencer: a link drop abandons the TLP, and a transfer advances it.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= HDR;
                HDR:     if (trn_lnk_up_n) state <= IDLE;
                         else if (!trn_tdst_rdy_n) state <= DAT;
                DAT:     if (trn_lnk_up_n || !trn_tdst_rdy_n) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request, including the requester ID, so the TLP cannot change while it is in flight.
    always_ff @(posedge sys_clk) begin
        // NOTE: payload registers have no reset; the beat mux forces trn_td to zero in IDLE, so stale contents are never visible.
        if (accept) begin
            addr_q   <= req_addr;
            data_q   <= req_data;
            be_q     <= req_be;
            req_id_q <= req_id;
        end
    end

    // Tag advances only when a complete TLP leaves; wraps naturally at 8 bits.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tag <= 8'h00;
        end else if (dat_done) begin
            tag <= tag + 8'd1;
        end
    end

    // Beat formatting is a pure function of state and captured request, so it holds during back-pressure.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        trn_td         = 64'h0;
        trn_trem_n     = 1'b0;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        case (state)
            HDR: begin
                trn_td         = {32'h4000_0001, req_id_q, tag, 4'h0, be_q};
                trn_tsof_n     = 1'b0;
                trn_tsrc_rdy_n = 1'b0;
            end
            DAT: begin
                trn_td         = {addr_q, 2'b00, data_q};
                trn_teof_n     = 1'b0;
                trn_tsrc_rdy_n = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef TRN_MWR_TX_STATS_EN
    assign unused_inputs = ^{trn_tbuf_av[5:2], trn_tbuf_av[0]};

    // Saturating statistics: completed TLPs and cycles flagged as dropped by the core.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_count   <= 16'h0000;
            drop_count <= 16'h0000;
        end else begin
            if (dat_done && tx_count != 16'hFFFF) begin
                tx_count <= tx_count + 16'd1;
            end
            if (!trn_terr_drop_n && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
`else
    assign unused_inputs = ^{trn_tbuf_av[5:2], trn_tbuf_av[0], trn_terr_drop_n};
    assign tx_count      = 16'h0000;
    assign drop_count    = 16'h0000;
`endif

endmodule

// File: tb/tb_trn_mwr_tx.sv
// Testbench for trn_mwr_tx. It drives random and directed requests and checks
// every beat against a transaction-level model: the expected header and data
// beats, the tag, and the statistics counters. It adapts its statistics
// expectations to whether TRN_MWR_TX_STATS_EN is defined.
module tb_trn_mwr_tx;

`ifdef TRN_MWR_TX_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif
    localparam int RID_CFG = 1;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic [29:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_be;
    logic [7:0]  cfg_bus_number;
    logic [4:0]  cfg_device_number;
    logic [2:0]  cfg_function_number;
    logic        trn_lnk_up_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;
    logic        trn_tcfg_req_n;
    logic        trn_terr_drop_n;
    logic [63:0] trn_td;
    logic        trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_terrfwd_n;
    logic        trn_tstr_n;
    logic        trn_tcfg_gnt_n;
    logic [15:0] tx_count;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model state
    int          tag_m;
    int          tx_m;
    int          drop_m;
    logic [63:0] last_hdr;
    logic [63:0] last_dat;

    trn_mwr_tx #(.REQ_ID_FROM_CFG(RID_CFG)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
        .cfg_bus_number(cfg_bus_number), .cfg_device_number(cfg_device_number),
        .cfg_function_number(cfg_function_number),
        .trn_lnk_up_n(trn_lnk_up_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
        .trn_tbuf_av(trn_tbuf_av), .trn_tcfg_req_n(trn_tcfg_req_n),
        .trn_terr_drop_n(trn_terr_drop_n),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_terrfwd_n(trn_terrfwd_n),
        .trn_tstr_n(trn_tstr_n), .trn_tcfg_gnt_n(trn_tcfg_gnt_n),
        .tx_count(tx_count), .drop_count(drop_count)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_rid();
        return (RID_CFG != 0) ? {cfg_bus_number, cfg_device_number, cfg_function_number} : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
        if (!STATS_EN) return 16'h0000;
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check_idle(input string name, input logic gnt_n, input logic rdy);
        check({name, ".tsrc_rdy_n"}, trn_tsrc_rdy_n, 1'b1);
        check({name, ".tsof_n"}, trn_tsof_n, 1'b1);
        check({name, ".teof_n"}, trn_teof_n, 1'b1);
        check({name, ".trem_n"}, trn_trem_n, 1'b0);
        check({name, ".td"}, trn_td, 64'h0);
        check({name, ".req_ready"}, req_ready, rdy);
        check({name, ".tcfg_gnt_n"}, trn_tcfg_gnt_n, gnt_n);
        check({name, ".tieoffs"}, {trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n}, 3'b111);
        check({name, ".tx_count"}, tx_count, exp_cnt(tx_m));
        check({name, ".drop_count"}, drop_count, exp_cnt(drop_m));
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        req_valid = 1'b0;
        step();
        @(negedge sys_clk);
        tag_m = 0; tx_m = 0; drop_m = 0;
        check_idle("reset", 1'b1, 1'b0);
        step();
        sys_rst = 1'b0;
    endtask

    // One request from IDLE through both beats; the caller is 1 time unit past a posedge with the DUT idle.
    task automatic send(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b,
                        input int stall_h, input int stall_d, input bit cfg_mid, input bit drop_dat);
        logic [63:0] eh;
        logic [63:0] ed;
        req_addr = a; req_data = d; req_be = b; req_valid = 1'b1;
        @(negedge sys_clk);
        check_idle("pre_req", 1'b1, 1'b1);
        eh = {32'h4000_0001, exp_rid(), 8'(tag_m), 4'h0, b};
        ed = {a, 2'b00, d};
        step();
        req_valid = 1'b0;
        req_addr = 30'($urandom); req_data = $urandom; req_be = 4'($urandom);
        if (cfg_mid) trn_tcfg_req_n = 1'b0;
        for (int i = 0; i <= stall_h; i++) begin
            trn_tdst_rdy_n = (i < stall_h);
            @(negedge sys_clk);
            check("hdr.td", trn_td, eh);
            check("hdr.frame", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}, 4'b0010);
            check("hdr.req_ready", req_ready, 1'b0);
            check("hdr.tcfg_gnt_n", trn_tcfg_gnt_n, 1'b1);
            if (i == 0) last_hdr = trn_td;
            step();
        end
        for (int i = 0; i <= stall_d; i++) begin
            trn_tdst_rdy_n = (i < stall_d);
            if (drop_dat && i == stall_d) trn_lnk_up_n = 1'b1;
            @(negedge sys_clk);
            check("dat.td", trn_td, ed);
            check("dat.frame", {trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n}, 4'b0100);
            check("dat.req_ready", req_ready, 1'b0);
            check("dat.tcfg_gnt_n", trn_tcfg_gnt_n, 1'b1);
            if (i == 0) last_dat = trn_td;
            step();
        end
        if (!drop_dat) begin
            tag_m = (tag_m + 1) % 256;
            tx_m++;
        end
        trn_lnk_up_n = 1'b0;
        trn_tdst_rdy_n = 1'b0;
        trn_tcfg_req_n = 1'b1;
    endtask

    initial begin
        sys_rst = 1'b1; req_valid = 1'b0;
        req_addr = '0; req_data = '0; req_be = '0;
        cfg_bus_number = 8'd1; cfg_device_number = 5'd0; cfg_function_number = 3'd0;
        trn_lnk_up_n = 1'b0; trn_tdst_rdy_n = 1'b0; trn_tbuf_av = 6'h3F;
        trn_tcfg_req_n = 1'b1; trn_terr_drop_n = 1'b1;
        tag_m = 0; tx_m = 0; drop_m = 0;

        // Known-answer write, then confirm the tag moved to 1
        do_reset();
        send(30'h0400_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, 1'b0);
        check("ka.hdr", last_hdr, 64'h4000_0001_0100_000F);
        check("ka.dat", last_dat, 64'h1000_0000_DEAD_BEEF);
        send(30'($urandom), $urandom, 4'($urandom), 0, 0, 1'b0, 1'b0);
        check("ka.next_tag", last_hdr[15:8], 8'h01);

        // Back-pressure for 5 cycles in HDR
        do_reset();
        send(30'($urandom), $urandom, 4'($urandom), 5, 0, 1'b0, 1'b0);
        @(negedge sys_clk);
        check("stall.tx_count", tx_count, STATS_EN ? 16'd1 : 16'd0);
        step();

        // Config request: granted in IDLE and blocks requests, never granted mid-TLP
        trn_tcfg_req_n = 1'b0; req_valid = 1'b1;
        @(negedge sys_clk);
        check("cfg.idle_gnt_n", trn_tcfg_gnt_n, 1'b0);
        check("cfg.idle_ready", req_ready, 1'b0);
        step();
        trn_tcfg_req_n = 1'b1; req_valid = 1'b0;
        send(30'($urandom), $urandom, 4'($urandom), 1, 1, 1'b1, 1'b0);
        trn_tcfg_req_n = 1'b0;
        @(negedge sys_clk);
        check("cfg.after_gnt_n", trn_tcfg_gnt_n, 1'b0);
        step();
        trn_tcfg_req_n = 1'b1;

        // Link drop in DAT while the sink is ready: abandoned, tag and tx unchanged
        send(30'($urandom), $urandom, 4'($urandom), 0, 1, 1'b0, 1'b1);
        @(negedge sys_clk);
        check_idle("lnkdrop", 1'b1, 1'b1);
        step();
        send(30'($urandom), $urandom, 4'($urandom), 0, 0, 1'b0, 1'b0);
        trn_lnk_up_n = 1'b1;
        @(negedge sys_clk);
        check("lnkdown.ready", req_ready, 1'b0);
        step();
        trn_lnk_up_n = 1'b0; trn_tbuf_av = 6'h3D;
        @(negedge sys_clk);
        check("tbuf.ready", req_ready, 1'b0);
        step();
        trn_tbuf_av = 6'h3F;

        // Reset in the middle of a TLP
        req_valid = 1'b1;
        step();
        req_valid = 1'b0; trn_tdst_rdy_n = 1'b1;
        @(negedge sys_clk);
        check("midrst.busy", trn_tsrc_rdy_n, 1'b0);
        sys_rst = 1'b1;
        step();
        trn_tdst_rdy_n = 1'b0;
        @(negedge sys_clk);
        tag_m = 0; tx_m = 0; drop_m = 0;
        check_idle("midrst", 1'b1, 1'b0);
        step();
        sys_rst = 1'b0;
        send(30'($urandom), $urandom, 4'($urandom), 0, 0, 1'b0, 1'b0);
        check("midrst.tag", last_hdr[15:8], 8'h00);

        // Dropped-TLP indication for 3 cycles from a clean reset
        do_reset();
        trn_terr_drop_n = 1'b0;
        repeat (3) step();
        trn_terr_drop_n = 1'b1;
        drop_m += 3;
        @(negedge sys_clk);
        check("drop.count", drop_count, STATS_EN ? 16'd3 : 16'd0);
        step();

        // 257 back-to-back requests: tag wraps to 0 on the 257th header
        do_reset();
        for (int n = 0; n < 257; n++) begin
            send(30'($urandom), $urandom, 4'($urandom),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end
        check("wrap.tag257", last_hdr[15:8], 8'h00);

        // Random mix with link drops and changing requester ID
        for (int n = 0; n < 60; n++) begin
            cfg_bus_number = 8'($urandom);
            cfg_device_number = 5'($urandom);
            cfg_function_number = 3'($urandom);
            send(30'($urandom), $urandom, 4'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'b0, ($urandom_range(0, 5) == 0));
        end
        @(negedge sys_clk);
        check_idle("final", 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
